// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, 8 data bits LSB first,
// optional odd parity, one stop bit. Each byte is presented with a one-cycle strobe.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       data_strobe,
  output logic       rx_error
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CLOCKS = BAUD_CLOCKS / 2;
  localparam int CW          = $clog2(BAUD_CLOCKS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CLOCKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLOCKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic [1:0]    sync_vld;
  logic          prev_din;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          parity_err;
  logic          s_din;
  logic          fall;

  assign s_din = sync_q[1];
  // armed only once s_din carries a real (post-reset) high, so a line held low
  // through reset release cannot fake a start edge against the reset-high flops.
  assign fall  = armed & prev_din & ~s_din;

  // data_strobe is a valid with no ready: the consumer must take dout/rx_error
  // in the cycle data_strobe is high; both hold until the next strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_q      <= 2'b11;
      sync_vld    <= 2'b00;
      prev_din    <= 1'b1;
      armed       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift_q     <= 8'd0;
      parity_err  <= 1'b0;
      dout        <= 8'd0;
      busy        <= 1'b0;
      data_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], din};
      sync_vld    <= {sync_vld[0], 1'b1};
      prev_din    <= s_din;
      armed       <= armed | (sync_vld[1] & s_din);
      data_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state      <= START;
            cnt        <= '0;
            busy       <= 1'b1;
            parity_err <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!s_din) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= '0;
            shift_q <= {s_din, shift_q[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PAR: begin
          if (cnt == BAUD_LAST) begin
            cnt        <= '0;
            parity_err <= ~(^shift_q ^ s_din);
            state      <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          // Back in IDLE at mid-stop so an immediately following start edge is caught.
          if (cnt == BAUD_LAST) begin
            cnt         <= '0;
            dout        <= shift_q;
            rx_error    <= parity_err | ~s_din;
            data_strobe <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 32 clocks per bit, table vectors, hand sequences for corner
// cases, and random frames checked against a count-of-ones parity model.
module tb_uart_rx;

  localparam int BAUD = 32;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_dout;
    logic       exp_err;
    int         gap;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       sel_np = 1'b0;
  logic       din, din_np;
  logic [7:0] dout, dout_np;
  logic       busy, busy_np, data_strobe, data_strobe_np, rx_error, rx_error_np;
  logic       prev_strobe = 1'b0;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         strobe_count = 0;
  int         np_strobe_count = 0;
  logic [8:0] exp_q[$];
  vec_t       vecs[5];

  assign din    = sel_np ? 1'b1 : line;
  assign din_np = sel_np ? line : 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQUENCY(3_200_000), .BAUD_RATE(100_000), .PARITY(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .busy(busy),
    .data_strobe(data_strobe), .rx_error(rx_error)
  );

  uart_rx #(.CLK_FREQUENCY(3_200_000), .BAUD_RATE(100_000), .PARITY(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .din(din_np), .dout(dout_np), .busy(busy_np),
    .data_strobe(data_strobe_np), .rx_error(rx_error_np)
  );

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard: every strobe must match the head of exp_q
  always @(negedge clk) begin
    if (data_strobe) begin
      strobe_count++;
      check("strobe_width", {8'd0, prev_strobe}, 9'd0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_strobe actual=%h required=none", {rx_error, dout});
      end else begin
        check("rx_byte", {rx_error, dout}, exp_q.pop_front());
      end
    end
    if (data_strobe_np) np_strobe_count++;
    prev_strobe = data_strobe;
  end

  // driver tasks
  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit,
                            input bit with_par);
    line = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_at_start", {8'd0, sel_np ? busy_np : busy}, 9'd1);
    repeat (BAUD - 6) @(negedge clk);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
    check("busy_mid", {8'd0, sel_np ? busy_np : busy}, 9'd1);
    if (with_par) hold(par_bit, BAUD);
    hold(stop_bit, BAUD);
    line = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 24 * BAUD) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] c3;
    logic       pbit, sbit, exp_err;
    int         sc, n;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, BAUD};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, BAUD};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, BAUD};
    vecs[3] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 2 * BAUD};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, BAUD};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_dout", {1'b0, dout}, 9'h000);
    check("reset_busy", {8'd0, busy}, 9'd0);
    check("reset_strobe", {8'd0, data_strobe}, 9'd0);
    check("reset_rx_error", {8'd0, rx_error}, 9'd0);

    hold(1'b1, 1000);
    check("idle_busy", {8'd0, busy}, 9'd0);
    check("idle_strobes", 9'(strobe_count), 9'd0);
    check("idle_dout", {rx_error, dout}, 9'h000);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_dout});
      send_frame(vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit, 1'b1);
      hold(1'b1, vecs[i].gap);
      wait_drain("vec");
      check("busy_after", {8'd0, busy}, 9'd0);
    end

    // glitch shorter than half a bit: false start, no strobe
    sc = strobe_count;
    line = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_high", {8'd0, busy}, 9'd1);
    repeat (2) @(negedge clk);
    hold(1'b1, 22);
    check("glitch_busy_low", {8'd0, busy}, 9'd0);
    hold(1'b1, 4 * BAUD);
    check("glitch_no_strobe", 9'(strobe_count - sc), 9'd0);

    // back-to-back frames, zero idle gap
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'hFE});
    exp_q.push_back({1'b0, 8'h7F});
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b1, 1'b1);
    send_frame(8'h7F, 1'b0, 1'b1, 1'b1);
    wait_drain("back_to_back");

    // reset during data bit 4 of 0xC3, line low across reset release
    sc = strobe_count;
    c3 = 8'hC3;
    hold(1'b0, BAUD);
    for (int i = 0; i < 4; i++) hold(c3[i], BAUD);
    hold(c3[4], BAUD / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", {8'd0, busy}, 9'd0);
    check("midreset_out", {rx_error, dout}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    hold(c3[4], BAUD / 2 - 2);
    hold(1'b1, 3 * BAUD);
    check("midreset_busy_after", {8'd0, busy}, 9'd0);
    check("midreset_no_strobe", 9'(strobe_count - sc), 9'd0);
    exp_q.push_back({1'b0, 8'h42});
    send_frame(8'h42, 1'b1, 1'b1, 1'b1);
    hold(1'b1, BAUD);
    wait_drain("after_reset");

    // random frames against a count-of-ones model
    for (int k = 0; k < 20; k++) begin
      b    = 8'($urandom_range(0, 255));
      pbit = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      exp_err = ((($countones(b) + int'(pbit)) % 2) == 0) || (sbit == 1'b0);
      exp_q.push_back({exp_err, b});
      send_frame(b, pbit, sbit, 1'b1);
      hold(1'b1, (sbit == 1'b0) ? 2 * BAUD : $urandom_range(0, BAUD));
      wait_drain("random");
    end

    // no-parity instance
    check("np_idle_strobes", 9'(np_strobe_count), 9'd0);
    sel_np = 1'b1;
    hold(1'b1, 2 * BAUD);
    send_frame(8'h99, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (np_strobe_count == 0 && n < 4 * BAUD) begin
      @(negedge clk);
      n++;
    end
    check("np_strobes", 9'(np_strobe_count), 9'd1);
    check("np_byte", {rx_error_np, dout_np}, {1'b0, 8'h99});
    hold(1'b1, BAUD);
    check("np_busy_after", {8'd0, busy_np}, 9'd0);
    sel_np = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
